// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared widths, requester ids and one-hot helper for the writeback controller
package regfile_ctrl_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] idx);
    onehot = NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin arbiter; priority flips to the other input after every grant
module rr_arbiter2
  import regfile_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // prio names the requester that wins when both ask
  logic prio;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = prio ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'(REQ_ALU);
    end else if (advance && (grant != 2'b00)) begin
      prio <= grant[REQ_ALU];
    end
  end

endmodule

// File: rtl/regfile_wb_controller.sv
// rtl/regfile_wb_controller.sv - register file write port owner with RR writeback arbitration and hazard scoreboard
// Optional macro WRITE_BYPASS_EN adds forwarding of the in-progress write to issue operands.
module regfile_wb_controller
  import regfile_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clock_enable,
  input  logic                alu_wr_valid,
  input  logic [ADDR_W-1:0]   alu_wr_dest,
  input  logic [DATA_W-1:0]   alu_wr_data,
  output logic                alu_wr_ready,
  input  logic                mem_wr_valid,
  input  logic [ADDR_W-1:0]   mem_wr_dest,
  input  logic [DATA_W-1:0]   mem_wr_data,
  output logic                mem_wr_ready,
  output logic                reg_write_en,
  output logic [ADDR_W-1:0]   reg_write_dest,
  output logic [DATA_W-1:0]   reg_write_data,
  input  logic                issue_valid,
  input  logic                issue_use1,
  input  logic [ADDR_W-1:0]   issue_src1,
  input  logic                issue_use2,
  input  logic [ADDR_W-1:0]   issue_src2,
  input  logic                issue_wr,
  input  logic [ADDR_W-1:0]   issue_dest,
  output logic                issue_stall,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                err_orphan_wb
`ifdef WRITE_BYPASS_EN
  ,
  output logic                fwd1_en,
  output logic                fwd2_en,
  output logic [DATA_W-1:0]   fwd_data
`endif
);

  logic [1:0]          req;
  logic [1:0]          grant;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_dest_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [NUM_REGS-1:0] pend;
  logic                err_q;
  logic [NUM_REGS-1:0] wr_onehot;
  logic [NUM_REGS-1:0] raw_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic                hazard;

  assign req[REQ_ALU] = clock_enable & alu_wr_valid;
  assign req[REQ_MEM] = clock_enable & mem_wr_valid;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (clock_enable),
    .grant   (grant)
  );

  assign alu_wr_ready = grant[REQ_ALU];
  assign mem_wr_ready = grant[REQ_MEM];

  // a write held across a stall is presented only once clock_enable returns
  assign reg_write_en   = wr_en_q & clock_enable;
  assign reg_write_dest = wr_dest_q;
  assign reg_write_data = wr_data_q;
  assign pending_mask   = pend;
  assign err_orphan_wb  = err_q;

  assign wr_onehot = reg_write_en ? onehot(reg_write_dest) : '0;

`ifdef WRITE_BYPASS_EN
  assign raw_mask = pend & ~wr_onehot;
  assign fwd1_en  = reg_write_en & issue_use1 & (reg_write_dest == issue_src1);
  assign fwd2_en  = reg_write_en & issue_use2 & (reg_write_dest == issue_src2);
  assign fwd_data = reg_write_data;
`else
  assign raw_mask = pend;
`endif

  assign hazard = (issue_use1 & raw_mask[issue_src1]) |
                  (issue_use2 & raw_mask[issue_src2]) |
                  (issue_wr   & pend[issue_dest]);

  assign issue_stall = issue_valid & (~clock_enable | hazard);
  assign set_mask    = (issue_valid & issue_wr & ~issue_stall) ? onehot(issue_dest) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_dest_q <= '0;
      wr_data_q <= '0;
      pend      <= '0;
      err_q     <= 1'b0;
    end else if (clock_enable) begin
      wr_en_q <= |grant;
      if (|grant) begin
        wr_dest_q <= grant[REQ_MEM] ? mem_wr_dest : alu_wr_dest;
        wr_data_q <= grant[REQ_MEM] ? mem_wr_data : alu_wr_data;
      end
      // set applied after clear so a same-cycle reserve of the written register wins
      pend <= (pend & ~wr_onehot) | set_mask;
      if (reg_write_en && !pend[reg_write_dest]) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/regfile_wb_controller.md
Name: regfile_wb_controller

Overview:
- Owns the single write port of the 8x16 register file.
- Arbitrates round-robin between two writeback requesters, the ALU and the memory-load path, using a valid/ready handshake.
- Drives the register file write port from a registered stage.
- Keeps a pending-write scoreboard and stalls issue on RAW/WAW hazards.
- Sits between the decode/issue stage, the execution units and the register file.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 3, register address width
- NUM_REGS, 8, number of registers (2**ADDR_W)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous reset, active-high
- clock_enable  in  1  global stall; 0 freezes all state
- alu_wr_valid  in  1  ALU writeback request
- alu_wr_dest  in  ADDR_W  ALU destination register
- alu_wr_data  in  DATA_W  ALU result
- alu_wr_ready  out  1  ALU request accepted this cycle
- mem_wr_valid  in  1  load writeback request
- mem_wr_dest  in  ADDR_W  load destination register
- mem_wr_data  in  DATA_W  load data
- mem_wr_ready  out  1  load request accepted this cycle
- reg_write_en  out  1  to register file write enable
- reg_write_dest  out  ADDR_W  to register file write address
- reg_write_data  out  DATA_W  to register file write data
- issue_valid  in  1  instruction presented for issue
- issue_use1  in  1  instruction reads src1
- issue_src1  in  ADDR_W  source register 1
- issue_use2  in  1  instruction reads src2
- issue_src2  in  ADDR_W  source register 2
- issue_wr  in  1  instruction will write issue_dest
- issue_dest  in  ADDR_W  destination register
- issue_stall  out  1  hazard; instruction must hold
- pending_mask  out  NUM_REGS  scoreboard bits, bit i = write to Ri outstanding
- err_orphan_wb  out  1  sticky; writeback to a non-pending register

Behaviour:
- Reset (reset=1 at posedge) clears all state:
  - reg_write_en=0, reg_write_dest=0, reg_write_data=0
  - pending_mask=0, err_orphan_wb=0
  - round-robin priority set to ALU
- Arbitration is combinational, only when clock_enable=1:
  - Exactly one valid requester: that requester's ready=1.
  - Both valid: the priority holder gets ready=1. After any grant, priority passes to the other requester.
  - A requester that is not granted holds valid/dest/data stable until granted.
- Write stage latency is 1 cycle:
  - A handshake (valid&ready) in cycle N registers dest/data, and reg_write_en=1 in cycle N+1.
  - The register file writes at the end of cycle N+1.
  - With no handshake, the registered enable is 0 the next cycle.
- Scoreboard is updated at each posedge with clock_enable=1:
  - clear bit reg_write_dest if reg_write_en=1
  - set bit issue_dest if issue_valid & issue_wr & !issue_stall
  - same bit set and cleared together: set wins
- issue_stall = issue_valid & (issue_use1&pend[src1] | issue_use2&pend[src2] | issue_wr&pend[dest]). pend is pending_mask.
- issue_stall=0 whenever issue_valid=0.
- err_orphan_wb is set at the posedge where reg_write_en=1 and pending_mask[reg_write_dest]=0. It is cleared only by reset. The write is still performed.
- clock_enable=0:
  - alu_wr_ready=mem_wr_ready=0
  - issue_stall=1 if issue_valid
  - reg_write_en output gated to 0, so no double write
  - all registers hold; a held write completes in the first cycle clock_enable returns to 1
- Reset mid-operation: any in-flight registered write is dropped and all pending bits are lost. Upstream is reset by the same signal.

Optional Feature:
- Macro WRITE_BYPASS_EN.
- Defined:
  - Adds outputs fwd1_en, fwd2_en (1 bit each) and fwd_data (DATA_W).
  - fwdK_en=1 when reg_write_en & issue_useK & reg_write_dest==issue_srcK.
  - fwd_data=reg_write_data.
  - Hazard terms for src1/src2 use pend & ~onehot(reg_write_dest) when reg_write_en=1, so a RAW on the register being written this cycle does not stall. The WAW term is unchanged.
- Not defined: no fwd ports; the RAW stall persists until the cycle after the write.

Decomposition:
- Package regfile_ctrl_pkg holds:
  - DATA_W/ADDR_W/NUM_REGS constants
  - requester id constants REQ_ALU=0, REQ_MEM=1
- Sub-module rr_arbiter2: 2-input round-robin arbiter.
  - Inputs: req[1:0], advance, clk, reset
  - Output: one-hot grant
  - Instantiated once.
- The scoreboard stays inline.

Test Plan:
- Reset: hold reset 2 cycles -> reg_write_en=0, pending_mask=8'h00, err_orphan_wb=0, issue_stall=0.
- Single ALU write: issue dest=R3 (pending_mask=8'h08). ALU valid dest=3 data=16'hBEEF -> ready same cycle; next cycle reg_write_en=1, dest=3, data=16'hBEEF; following cycle pending_mask=8'h00.
- Contention: ALU and MEM valid every cycle for 4 cycles -> grants ALU, MEM, ALU, MEM; the losing requester's data appears unchanged on reg_write_data one cycle after its grant.
- RAW stall: pending R5, issue use1 src1=5 -> issue_stall=1 until the cycle after the R5 write (1 cycle earlier with WRITE_BYPASS_EN, fwd1_en=1, fwd_data=the R5 write data).
- WAW and set-wins: pending R2 being written while a new issue reserves R2 in the same cycle -> issue_stall=1 (WAW); after the write clears the bit, the next issue sets it and pending_mask[2]=1.
- clock_enable low: drop clock_enable for 3 cycles with a write registered -> reg_write_en=0, readies=0, state held; the write occurs exactly once after re-enable. A write to non-pending R7 -> err_orphan_wb=1 and stays set.
